// File: rtl/nmea_rmc_tx.sv
// -----------------------------------------------------------------------------
// nmea_rmc_tx
//
// Formats and streams a short NMEA RMC sentence to a byte-wide UART
// transmitter, one byte per request/acknowledge handshake:
//
//     "$GNRMC,hhmmss.00,S*CC\r\n"   (23 bytes, index 0..22)
//
// The time and fix status are captured when a sentence starts, so the caller
// may change them freely while the sentence is in flight. The checksum is an
// XOR over the bytes between '$' and '*', built up as those bytes go out, and
// is then sent as two uppercase hex characters. If the UART never
// acknowledges a byte within TIMEOUT_CYC cycles, the sentence is abandoned
// and err pulses.
//
// Parameters
//   TIMEOUT_CYC   max cycles spent waiting for i_tx_done on one byte
//
// Ports
//   sys_clk       system clock, rising edge
//   sys_rst_n     asynchronous active-low reset
//   i_start       one-cycle request to send a sentence (IDLE only)
//   i_time_bcd    {hh, mm, ss} as six BCD nibbles, most significant first
//   i_time_valid  fix status, 1 -> 'A', 0 -> 'V'
//   i_tx_done     one-cycle acknowledge from the UART for the current byte
//   o_tx_data     byte presented to the UART, valid with o_tx_flag
//   o_tx_flag     one-cycle strobe requesting the UART to send o_tx_data
//   o_busy        sentence in progress
//   o_done        one-cycle pulse when the final LF has been acknowledged
//   o_err         one-cycle pulse when a byte acknowledge timed out
// -----------------------------------------------------------------------------
module nmea_rmc_tx #(
    parameter logic [19:0] TIMEOUT_CYC = 20'd1_000_000
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        i_start,
    input  logic [23:0] i_time_bcd,
    input  logic        i_time_valid,
    input  logic        i_tx_done,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_flag,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [4:0] LAST_IDX  = 5'd22;
    localparam logic [4:0] CSUM_FIRST = 5'd1;
    localparam logic [4:0] CSUM_LAST  = 5'd17;

    state_t      r_state;
    state_t      w_next_state;
    logic [4:0]  r_index;
    logic [7:0]  r_csum;
    logic [19:0] r_wait_cnt;
    logic [23:0] r_time;
    logic        r_valid;

    logic [7:0]  w_byte;
    logic        w_bad_digit;
    logic        w_term_cnt;

    // A nibble that is not a legal BCD digit is sent as '0'.
    function automatic logic [7:0] digit_char(input logic [3:0] nib);
        return (nib > 4'd9) ? 8'h30 : {4'h3, nib};
    endfunction

    // Uppercase hex: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib > 4'd9) ? (8'h37 + {4'h0, nib}) : {4'h3, nib};
    endfunction

    // Any illegal digit in the captured time makes the fix untrustworthy,
    // so the status character is forced to 'V' below.
    always_comb begin
        w_bad_digit = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (r_time[4*k +: 4] > 4'd9) begin
                w_bad_digit = 1'b1;
            end
        end
    end

    // Byte for the current index. The checksum characters read r_csum,
    // which by index 19 already holds the XOR of indices 1..17.
    always_comb begin
        w_byte = 8'h00;
        case (r_index)
            5'd0:    w_byte = "$";
            5'd1:    w_byte = "G";
            5'd2:    w_byte = "N";
            5'd3:    w_byte = "R";
            5'd4:    w_byte = "M";
            5'd5:    w_byte = "C";
            5'd6:    w_byte = ",";
            5'd7:    w_byte = digit_char(r_time[23:20]);
            5'd8:    w_byte = digit_char(r_time[19:16]);
            5'd9:    w_byte = digit_char(r_time[15:12]);
            5'd10:   w_byte = digit_char(r_time[11:8]);
            5'd11:   w_byte = digit_char(r_time[7:4]);
            5'd12:   w_byte = digit_char(r_time[3:0]);
            5'd13:   w_byte = ".";
            5'd14:   w_byte = "0";
            5'd15:   w_byte = "0";
            5'd16:   w_byte = ",";
            5'd17:   w_byte = (r_valid && !w_bad_digit) ? "A" : "V";
            5'd18:   w_byte = "*";
            5'd19:   w_byte = hex_char(r_csum[7:4]);
            5'd20:   w_byte = hex_char(r_csum[3:0]);
            5'd21:   w_byte = 8'h0D;
            5'd22:   w_byte = 8'h0A;
            default: w_byte = 8'h00;
        endcase
    end

    assign w_term_cnt = (r_wait_cnt == (TIMEOUT_CYC - 20'd1));

    // State register.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state and outputs. In WAIT an acknowledge takes priority over the
    // timeout, so a tx_done landing on the terminal count still advances.
    always_comb begin
        w_next_state = r_state;
        o_tx_data    = 8'h00;
        o_tx_flag    = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_SEND;
                end
            end
            S_SEND: begin
                o_tx_flag    = 1'b1;
                o_tx_data    = w_byte;
                o_busy       = 1'b1;
                w_next_state = S_WAIT;
            end
            S_WAIT: begin
                o_busy = 1'b1;
                if (i_tx_done) begin
                    w_next_state = (r_index == LAST_IDX) ? S_FINISH : S_SEND;
                end else if (w_term_cnt) begin
                    o_err        = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_FINISH: begin
                o_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Datapath: capture inputs on start, accumulate the checksum as each
    // covered byte is emitted, run the per-byte wait counter, and step the
    // index on each accepted acknowledge.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_index    <= 5'd0;
            r_csum     <= 8'h00;
            r_wait_cnt <= 20'd0;
            r_time     <= 24'h000000;
            r_valid    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_time  <= i_time_bcd;
                        r_valid <= i_time_valid;
                        r_index <= 5'd0;
                        r_csum  <= 8'h00;
                    end
                end
                S_SEND: begin
                    r_wait_cnt <= 20'd0;
                    if ((r_index >= CSUM_FIRST) && (r_index <= CSUM_LAST)) begin
                        r_csum <= r_csum ^ w_byte;
                    end
                end
                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt + 20'd1;
                    if (i_tx_done && (r_index != LAST_IDX)) begin
                        r_index <= r_index + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nmea_rmc_tx.sv
// -----------------------------------------------------------------------------
// tb_nmea_rmc_tx
//
// Drives nmea_rmc_tx with a cycle-stepped UART responder and compares every
// emitted byte, strobe timing, done/err pulse and busy level against a
// sentence built directly from the text format (string pieces plus XOR).
// -----------------------------------------------------------------------------
module tb_nmea_rmc_tx;

    localparam int TIMEOUT = 20;

    logic        sys_clk      = 1'b0;
    logic        sys_rst_n    = 1'b0;
    logic        i_start      = 1'b0;
    logic [23:0] i_time_bcd   = 24'h000000;
    logic        i_time_valid = 1'b0;
    logic        i_tx_done    = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_flag;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [7:0]  expBytes [23];
    logic [7:0]  gotBytes [23];
    string       litNominal;
    string       litVoid;
    logic [23:0] randTime;

    nmea_rmc_tx #(
        .TIMEOUT_CYC(20'd20)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .i_start     (i_start),
        .i_time_bcd  (i_time_bcd),
        .i_time_valid(i_time_valid),
        .i_tx_done   (i_tx_done),
        .o_tx_data   (o_tx_data),
        .o_tx_flag   (o_tx_flag),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_err       (o_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] hexChar(input logic [3:0] n);
        string digits = "0123456789ABCDEF";
        return digits[int'(n)];
    endfunction

    // Reference sentence built from the text layout of an RMC sentence.
    task automatic modelSentence(input logic [23:0] t, input logic v);
        string      head = "$GNRMC,";
        string      mid  = ".00,";
        logic       bad;
        logic [3:0] nib;
        logic [7:0] cs;
        bad = 1'b0;
        for (int i = 0; i < 7; i++) expBytes[i] = head[i];
        for (int k = 0; k < 6; k++) begin
            nib = t[23-4*k -: 4];
            if (nib > 4'd9) begin
                bad = 1'b1;
                expBytes[7+k] = "0";
            end else begin
                expBytes[7+k] = 8'h30 + {4'h0, nib};
            end
        end
        for (int i = 0; i < 4; i++) expBytes[13+i] = mid[i];
        expBytes[17] = (v && !bad) ? "A" : "V";
        cs = 8'h00;
        for (int i = 1; i <= 17; i++) cs = cs ^ expBytes[i];
        expBytes[18] = "*";
        expBytes[19] = hexChar(cs[7:4]);
        expBytes[20] = hexChar(cs[3:0]);
        expBytes[21] = 8'h0D;
        expBytes[22] = 8'h0A;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_data"}, o_tx_data, 0);
        checkOutput({tag, "_flag"}, o_tx_flag, 0);
        checkOutput({tag, "_busy"}, o_busy, 0);
        checkOutput({tag, "_done"}, o_done, 0);
        checkOutput({tag, "_err"},  o_err, 0);
    endtask

    // Runs one sentence. Step 0 is the start cycle; inputs for a step are
    // set at its falling edge and outputs are sampled 1 ns later.
    //   withholdIdx  byte index whose tx_done is never given (-1: none)
    //   fixedDelay   tx_done delay after each strobe (0: random 1..TIMEOUT)
    //   midStartStep step at which a stray start with new data is pulsed
    //   resetAt      byte index at whose strobe reset is asserted (-1: none)
    //   chain        pulse start in the done cycle and return immediately
    task automatic applyStimulus(input logic [23:0] t, input logic v, input int withholdIdx,
                                 input int fixedDelay, input int midStartStep,
                                 input int resetAt, input bit chain);
        int nFlags     = 0;
        int expFlagCyc = 1;
        int nextDone   = -1;
        int expDoneCyc = -1;
        int expErrCyc  = -1;
        int doneCnt    = 0;
        int errCnt     = 0;
        int doneCyc    = -1;
        int errCyc     = -1;
        int endStep    = -1;
        int delay      = 1;
        bit stop       = 1'b0;
        modelSentence(t, v);
        @(negedge sys_clk);
        i_time_bcd   = t;
        i_time_valid = v;
        i_start      = 1'b1;
        i_tx_done    = 1'b0;
        for (int step = 0; step < 1200 && !stop; step++) begin
            if (step > 0) begin
                @(negedge sys_clk);
                i_start = (step == midStartStep);
                if (step == midStartStep) begin
                    i_time_bcd   = ~t;
                    i_time_valid = ~v;
                end
                i_tx_done = (step == nextDone);
            end
            #1;
            if (step == 0) checkOutput("busyAtStart", o_busy, 0);
            if (step == 1) checkOutput("busyFirstFlag", o_busy, 1);
            if (o_tx_flag) begin
                checkOutput($sformatf("flagCycle%0d", nFlags), step, expFlagCyc);
                if (nFlags < 23) begin
                    gotBytes[nFlags] = o_tx_data;
                    checkOutput($sformatf("byte%0d", nFlags), o_tx_data, expBytes[nFlags]);
                end
                delay = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(1, TIMEOUT));
                if (nFlags == withholdIdx) begin
                    nextDone   = -1;
                    expFlagCyc = -1;
                    expErrCyc  = step + TIMEOUT;
                end else if (nFlags == 22) begin
                    nextDone   = step + delay;
                    expFlagCyc = -1;
                    expDoneCyc = nextDone + 1;
                end else begin
                    nextDone   = step + delay;
                    expFlagCyc = nextDone + 1;
                end
                nFlags++;
                if (nFlags - 1 == resetAt) begin
                    sys_rst_n = 1'b0;
                    #1;
                    checkAllZero("resetMid");
                    @(negedge sys_clk);
                    i_tx_done = 1'b0;
                    sys_rst_n = 1'b1;
                    stop = 1'b1;
                end
            end
            if (o_done) begin
                doneCnt++;
                doneCyc = step;
                endStep = step;
                checkOutput("busyAtDone", o_busy, 0);
                if (chain) begin
                    i_start = 1'b1;
                    stop    = 1'b1;
                end
            end
            if (o_err) begin
                errCnt++;
                errCyc  = step;
                endStep = step;
            end
            if (errCyc >= 0 && step == errCyc + 1) checkOutput("busyAfterErr", o_busy, 0);
            if (endStep >= 0 && step >= endStep + 30) stop = 1'b1;
        end
        if (resetAt < 0) begin
            checkOutput("flagCount", nFlags, (withholdIdx >= 0) ? withholdIdx + 1 : 23);
            checkOutput("doneCount", doneCnt, (withholdIdx >= 0) ? 0 : 1);
            checkOutput("errCount", errCnt, (withholdIdx >= 0) ? 1 : 0);
            if (withholdIdx >= 0) checkOutput("errCycle", errCyc, expErrCyc);
            else                  checkOutput("doneCycle", doneCyc, expDoneCyc);
        end
    endtask

    // Idle period: no strobe and no busy may appear; optionally pokes
    // stray tx_done pulses that must be ignored.
    task automatic checkQuiet(input int cycles, input bit poke);
        int flags    = 0;
        int busyHigh = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge sys_clk);
            i_start   = 1'b0;
            i_tx_done = poke && (i % 4 == 1);
            #1;
            if (o_tx_flag) flags++;
            if (o_busy) busyHigh++;
        end
        i_tx_done = 1'b0;
        checkOutput("quietFlags", flags, 0);
        checkOutput("quietBusy", busyHigh, 0);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        litNominal = "$GNRMC,123456.00,A*3D\r\n";
        litVoid    = "$GNRMC,000000.00,V*2D\r\n";
        repeat (3) @(negedge sys_clk);
        #1;
        checkAllZero("reset");
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        $display("[TB] nominal sentence");
        applyStimulus(24'h123456, 1'b1, -1, 10, -1, -1, 1'b0);
        for (int i = 0; i < 23; i++) checkOutput($sformatf("nominalLit%0d", i), gotBytes[i], litNominal[i]);

        $display("[TB] void status, zero time");
        applyStimulus(24'h000000, 1'b0, -1, 10, -1, -1, 1'b0);
        for (int i = 0; i < 23; i++) checkOutput($sformatf("voidLit%0d", i), gotBytes[i], litVoid[i]);

        $display("[TB] illegal digit");
        applyStimulus(24'h1A3456, 1'b1, -1, 10, -1, -1, 1'b0);

        $display("[TB] stray start mid-sentence");
        applyStimulus(24'h235959, 1'b1, -1, 0, 10, -1, 1'b0);

        $display("[TB] stray tx_done while idle");
        checkQuiet(30, 1'b1);

        $display("[TB] timeout on byte 5");
        applyStimulus(24'h101010, 1'b1, 5, 10, -1, -1, 1'b0);

        $display("[TB] tx_done on terminal count");
        applyStimulus(24'h081530, 1'b1, -1, TIMEOUT, -1, -1, 1'b0);

        $display("[TB] start in done cycle, then next cycle");
        applyStimulus(24'h111111, 1'b1, -1, 0, -1, -1, 1'b1);
        applyStimulus(24'h222222, 1'b0, -1, 0, -1, -1, 1'b0);

        $display("[TB] reset mid-sentence");
        applyStimulus(24'h204513, 1'b1, -1, 0, -1, 10, 1'b0);
        checkQuiet(30, 1'b0);
        applyStimulus(24'h195907, 1'b1, -1, 0, -1, -1, 1'b0);

        $display("[TB] random sentences");
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < 6; k++) begin
                randTime[4*k +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                                 : 4'($urandom_range(0, 9));
            end
            applyStimulus(randTime, 1'($urandom_range(0, 1)), -1, 0, -1, -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/nmea_rmc_tx.md
NMEA_RMC_TX -- requirements
Module: nmea_rmc_tx

Interface
REQ-001: Parameter TIMEOUT_CYC, default 20'd1_000_000, is the maximum number of sys_clk cycles to wait for tx_done per byte.
REQ-002: sys_clk  input  1  system clock; all logic is on the rising edge.
REQ-003: sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004: start  input  1  single-cycle request to send one sentence.
REQ-005: time_bcd  input  24  {hh_tens, hh_units, mm_tens, mm_units, ss_tens, ss_units}, 4-bit BCD each, MSB first.
REQ-006: time_valid  input  1  fix status: 1 sends 'A', 0 sends 'V'.
REQ-007: tx_done  input  1  single-cycle pulse from the UART transmitter when the current byte has been shifted out.
REQ-008: tx_data  output  8  ASCII byte to the UART transmitter.
REQ-009: tx_flag  output  1  single-cycle strobe; tx_data is valid in the same cycle.
REQ-010: busy  output  1  high from the cycle after start is accepted until the sentence completes or aborts.
REQ-011: done  output  1  single-cycle pulse when a sentence completes.
REQ-012: err  output  1  single-cycle pulse when a sentence aborts on timeout.

Function
REQ-013: Sentence format SHALL be "$GNRMC," + 6 time digits + ".00," + status + "*" + 2 checksum hex chars + 0x0D + 0x0A, for 23 bytes in total (byte index 0..22).
REQ-014: The FSM SHALL have the states IDLE, SEND, WAIT and FINISH.
- IDLE->SEND on start.
- SEND->WAIT always, after one cycle.
- WAIT->SEND on tx_done while index<22.
- WAIT->FINISH on tx_done while index==22.
- WAIT->IDLE on timeout.
- FINISH->IDLE always, after one cycle.
REQ-015: When start is accepted in IDLE, time_bcd and time_valid SHALL be latched, and the index and checksum SHALL be cleared, in the same edge; later input changes SHALL NOT affect the sentence in flight.
REQ-016: start SHALL be ignored in every state except IDLE.
REQ-017: In SEND, tx_flag SHALL be 1 for exactly one cycle with tx_data = byte[index].
- The first tx_flag ('$') SHALL occur 1 cycle after the start cycle.
- Each later tx_flag SHALL occur 1 cycle after the tx_done of the previous byte.
REQ-018: Each time digit SHALL be sent as 0x30 + BCD.
- A latched nibble >9 SHALL be sent as '0'.
- Any latched nibble >9 SHALL force the status character to 'V' regardless of time_valid.
REQ-019: The checksum SHALL be an 8-bit XOR, accumulated as each byte is emitted, over byte indices 1..17 only ("GNRMC,...,status"); '$', '*', the checksum characters and CR/LF SHALL be excluded.
REQ-020: The checksum SHALL be sent as two uppercase hex ASCII characters, high nibble first (0-9 -> 0x30-0x39, A-F -> 0x41-0x46).
REQ-021: tx_done SHALL be honoured only in WAIT; a tx_done in any other state SHALL be ignored.
REQ-022: The wait counter SHALL clear on entry to WAIT and count each cycle in WAIT.
- When it reaches TIMEOUT_CYC-1 without tx_done: err pulses 1 cycle, the FSM returns to IDLE, and no further tx_flag is issued.
- A tx_done in the same cycle as the terminal count SHALL win: no err, normal advance.
REQ-023: In FINISH, done SHALL pulse for 1 cycle and busy SHALL be 0 in that same cycle.
REQ-024: A start in the done cycle SHALL be ignored.
REQ-025: A start in the cycle after done SHALL be accepted.
REQ-026: busy SHALL be 1 in SEND and WAIT, and 0 in IDLE and FINISH.
REQ-027: At most one tx_flag SHALL be outstanding; there SHALL never be two tx_flag pulses without an intervening accepted tx_done.

Reset
REQ-028: Reset SHALL take effect asynchronously at any time, including mid-sentence.
- State: FSM=IDLE, index=0, checksum=0x00, wait counter=0, latched time=0, latched valid=0.
- Outputs: tx_data=0x00, tx_flag=0, busy=0, done=0, err=0.
REQ-029: After reset deasserts, no tx_flag SHALL occur until a new start; a partial sentence SHALL never be resumed.

Verification
REQ-030: Nominal sentence: time_bcd=24'h123456, time_valid=1, start pulse, UART model returns tx_done 10 cycles after each tx_flag -> bytes are exactly "$GNRMC,123456.00,A*3D\r\n" (23 tx_flag pulses), followed by a single done pulse.
REQ-031: Void status and even-digit cancellation: time_bcd=24'h000000, time_valid=0 -> "$GNRMC,000000.00,V*2D\r\n".
REQ-032: Illegal digit: time_bcd=24'h1A3456, time_valid=1 -> digit field "103456", status 'V', and the checksum recomputed on the bytes actually sent.
REQ-033: Busy/ignore rules:
- A start pulsed mid-sentence, with time_bcd changed, leaves the sentence unchanged and yields no second sentence.
- A spurious tx_done in IDLE produces no tx_flag.
REQ-034: Timeout, with TIMEOUT_CYC=20 and tx_done withheld after byte 5 -> err pulses 20 cycles after entering WAIT, busy drops, and no 7th tx_flag occurs. A second run with tx_done in the terminal cycle -> no err and normal continuation.
REQ-035: Reset mid-sentence: assert sys_rst_n=0 during byte 10 -> all outputs are 0 immediately; after release there is no tx_flag until start, and the next sentence begins with '$' and a correct checksum.
